mem_req_queue: RTL and testbench
================================

# mem_req_queue

Host-side request front end for the memory controller. Buffers host read/write requests in a FIFO and presents them one at a time on the controller's command interface (`cmd_n`, `RDnWR`, `Addr_in`, `Data_in_vld`, `Data_in`). It tracks each request to completion by watching the controller's `command`, `Data_out` and `data_out_vld` outputs, then returns a response pulse to the host. The block sits directly upstream of the controller; its controller-side outputs connect to the controller inputs of the same name.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 64: maximum cycles in WAIT before the request is aborted; range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  FIFO can accept a request; equals `!full`.
- `req_rdnwr`  in  1  1 = read, 0 = write.
- `req_addr`  in  16  `{row[3:0], col[11:0]}`.
- `req_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdnwr`  out  1  type of the completed request.
- `rsp_data`  out  32  read data; 0 for writes.
- `rsp_err`  out  1  qualifies `rsp_valid`; request timed out.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `cmd_n`  out  1  active-low request strobe to the controller.
- `RDnWR`  out  1  to the controller.
- `Addr_in`  out  16  to the controller.
- `Data_in_vld`  out  1  to the controller.
- `Data_in`  out  32  to the controller.
- `command`  in  3  controller command; 000 = NOP, 011 = WRITE.
- `Data_out`  in  32  controller read data.
- `data_out_vld`  in  1  controller read-data valid.

## Operation
- FIFO: entries are `{rdnwr, addr, wdata}` (49 bits). Read/write pointers are log2(DEPTH)+1 bits wide and wrap naturally. `full` when the pointers differ only in the MSB. `empty` when they are equal.
- Push condition: `req_valid && req_ready`.
- Pop condition: the transition IDLE→ISSUE. Pop reads the head entry into the `cur_*` holding registers.
- Push and pop in the same cycle: count unchanged. This is legal when full, because `req_ready` reflects the registered `full` only.
- FSM states: Q_IDLE, Q_ISSUE, Q_WAIT, Q_DONE.
  - Q_IDLE → Q_ISSUE when `!empty && command==000`. Otherwise stay in Q_IDLE.
  - Q_ISSUE (exactly one cycle): `cmd_n=0`. Next state is Q_WAIT. The timeout counter is loaded to 0.
  - Q_WAIT: `cmd_n=1`. `Data_in_vld=1` if `cur_rdnwr==0`. The counter increments each cycle.
    - Write completes on the first cycle with `command==011`.
    - Read completes on the first cycle with `data_out_vld==1`; `Data_out` is captured into `rsp_data`.
    - On completion, go to Q_DONE.
    - If the counter reaches TIMEOUT-1 without completion, go to Q_DONE with the error flag set.
    - If completion and timeout fall in the same cycle, completion wins: no error is reported.
  - Q_DONE (one cycle): `rsp_valid=1`, `rsp_err` = error flag, `rsp_rdnwr=cur_rdnwr`. Next state is Q_IDLE; the error flag clears.
- `RDnWR`, `Addr_in` and `Data_in` are driven from the `cur_*` registers. They stay stable from Q_ISSUE through Q_DONE and hold their last value in Q_IDLE.
- `rsp_*` outputs are registered. `rsp_data` holds its value until the next read completes; it is written to 0 on a write response.
- Only one request is outstanding at a time; there is no reordering.

## Timing
- Reset values (asynchronous):
  - FSM in Q_IDLE, pointers 0, `fifo_count=0`, `req_ready=1`.
  - `cmd_n=1`, `RDnWR=0`, `Addr_in=0`, `Data_in=0`, `Data_in_vld=0`.
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdnwr=0`, `rsp_data=0`.
- Reset asserted mid-request: the request and all FIFO contents are discarded, and no response is issued.
- Latency, with an empty FIFO and `command==000`:
  - Push at edge T.
  - Q_ISSUE (`cmd_n` low) during cycle T+1.
  - Q_WAIT from T+2.
  - `rsp_valid` one cycle after the completion cycle.
- Timeout response: `rsp_valid` with `rsp_err=1` is asserted TIMEOUT+1 cycles after Q_ISSUE.
- `fifo_count` updates on the edge following a push or pop.

## Test plan
- Reset then idle: `rsp_valid=0`, `cmd_n=1`, `req_ready=1`, `fifo_count=0` for 20 cycles.
- Write 0x1234→0xDEADBEEF with `command` returning 011 three cycles after `cmd_n` low:
  - `Addr_in=0x1234` and `Data_in=0xDEADBEEF` are held throughout.
  - `Data_in_vld` is high in Q_WAIT.
  - One `rsp_valid` pulse with `rsp_rdnwr=0`, `rsp_err=0`.
- Read 0xF00F with `data_out_vld` asserted and `Data_out=0xCAFEF00D`:
  - `rsp_valid` with `rsp_rdnwr=1` and `rsp_data=0xCAFEF00D` one cycle later.
- Fill with DEPTH=8 writes while `command` is held at 101:
  - `req_ready=0` at count 8; a 9th push is rejected.
  - After `command→000`, all 8 requests issue in order and count drains to 0.
- No completion ever: `rsp_valid=1` with `rsp_err=1` exactly 65 cycles after `cmd_n` low (TIMEOUT=64). The next queued request then issues.
- Reset asserted while in Q_WAIT with 3 entries queued: all outputs return to reset values immediately and `fifo_count=0`.

Source files
------------

// File: rtl/mem_req_queue.sv
// Host request front end for the memory controller: FIFO-buffers read/write
// requests, issues them one at a time and returns a response per request.
module mem_req_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rdnwr,
    input  logic [15:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_rdnwr,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     cmd_n,
    output logic                     RDnWR,
    output logic [15:0]              Addr_in,
    output logic                     Data_in_vld,
    output logic [31:0]              Data_in,
    input  logic [2:0]               command,
    input  logic [31:0]              Data_out,
    input  logic                     data_out_vld
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 49;
    localparam int unsigned TW = 8;
    localparam logic [2:0]    CMD_NOP   = 3'b000;
    localparam logic [2:0]    CMD_WRITE = 3'b011;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] FULL_XOR  = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        Q_IDLE  = 2'd0,
        Q_ISSUE = 2'd1,
        Q_WAIT  = 2'd2,
        Q_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr_next;
    logic [PW-1:0]   rptr_next;
    logic            push;
    logic            pop;
    logic            empty;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_cnt_next;
    logic            err;
    logic            err_next;
    logic            complete;

    assign empty     = (wptr == rptr);
    assign push      = req_valid && req_ready;
    assign head      = mem[rptr[AW-1:0]];
    assign wptr_next = wptr + PW'(push);
    assign rptr_next = rptr + PW'(pop);

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {req_rdnwr, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= Q_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        tmo_cnt_next = tmo_cnt;
        err_next     = err;
        complete     = 1'b0;
        case (state)
            Q_IDLE: begin
                if (!empty && (command == CMD_NOP)) begin
                    state_next = Q_ISSUE;
                    pop        = 1'b1;
                end
            end
            Q_ISSUE: begin
                state_next   = Q_WAIT;
                tmo_cnt_next = '0;
            end
            Q_WAIT: begin
                complete = RDnWR ? data_out_vld : (command == CMD_WRITE);
                // completion takes priority over a coincident timeout
                if (complete) begin
                    state_next = Q_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = Q_DONE;
                    err_next   = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end
            Q_DONE: begin
                state_next = Q_IDLE;
                err_next   = 1'b0;
            end
            default: begin
                state_next = Q_IDLE;
            end
        endcase
    end

    // Pointers, occupancy and host-side ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            req_ready  <= 1'b1;
            tmo_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            wptr       <= wptr_next;
            rptr       <= rptr_next;
            fifo_count <= wptr_next - rptr_next;
            req_ready  <= ((wptr_next ^ rptr_next) != FULL_XOR);
            tmo_cnt    <= tmo_cnt_next;
            err        <= err_next;
        end
    end

    // Current request holding registers double as the controller-side bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RDnWR   <= 1'b0;
            Addr_in <= '0;
            Data_in <= '0;
        end else if (pop) begin
            RDnWR   <= head[48];
            Addr_in <= head[47:32];
            Data_in <= head[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_n       <= 1'b1;
            Data_in_vld <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdnwr   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            cmd_n       <= (state_next != Q_ISSUE);
            Data_in_vld <= (state_next == Q_WAIT) && !RDnWR;
            rsp_valid   <= (state_next == Q_DONE);
            rsp_err     <= (state_next == Q_DONE) && err_next;
            if ((state == Q_WAIT) && (state_next == Q_DONE)) begin
                rsp_rdnwr <= RDnWR;
                if (!RDnWR) begin
                    rsp_data <= '0;
                end else if (complete) begin
                    rsp_data <= Data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: table-driven single transactions plus
// fill/drain, timeout and mid-request reset sequences.
module tb_mem_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rdnwr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_rdnwr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  fifo_count;
    logic        cmd_n;
    logic        RDnWR;
    logic [15:0] Addr_in;
    logic        Data_in_vld;
    logic [31:0] Data_in;
    logic [2:0]  command;
    logic [31:0] Data_out;
    logic        data_out_vld;

    int checks   = 0;
    int failures = 0;

    mem_req_queue #(.DEPTH(8), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rdnwr    (req_rdnwr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdnwr    (rsp_rdnwr),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .fifo_count   (fifo_count),
        .cmd_n        (cmd_n),
        .RDnWR        (RDnWR),
        .Addr_in      (Addr_in),
        .Data_in_vld  (Data_in_vld),
        .Data_in      (Data_in),
        .command      (command),
        .Data_out     (Data_out),
        .data_out_vld (data_out_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdnwr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;     // completion cycle counted from cmd_n low
        logic [31:0] rdata;
        logic        exp_rdnwr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cmd(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_cmd_n_low", 32'(ok), 32'd1);
    endtask

    task automatic push_req(input logic rd, input logic [15:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_rdnwr = rd;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        push_req(v.rdnwr, v.addr, v.wdata);
        chk("txn_count_after_push", 32'(fifo_count), 32'd1);
        chk("txn_cmd_n_idle", 32'(cmd_n), 32'd1);
        tick();
        chk("txn_cmd_n_issue", 32'(cmd_n), 32'd0);
        chk("txn_addr", 32'(Addr_in), 32'(v.addr));
        chk("txn_rdnwr", 32'(RDnWR), 32'(v.rdnwr));
        if (!v.rdnwr) chk("txn_wdata", Data_in, v.wdata);
        chk("txn_count_after_pop", 32'(fifo_count), 32'd0);
        tick();
        chk("txn_cmd_n_wait", 32'(cmd_n), 32'd1);
        for (int j = 1; j < v.delay; j++) begin
            chk("txn_din_vld", 32'(Data_in_vld), 32'(!v.rdnwr));
            chk("txn_no_early_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("txn_din_vld_last", 32'(Data_in_vld), 32'(!v.rdnwr));
        if (v.rdnwr) begin
            data_out_vld = 1'b1;
            Data_out     = v.rdata;
        end else begin
            command = 3'b011;
        end
        tick();
        command      = 3'b000;
        data_out_vld = 1'b0;
        Data_out     = 32'h0BAD_0BAD;
        chk("txn_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("txn_rsp_rdnwr", 32'(rsp_rdnwr), 32'(v.exp_rdnwr));
        chk("txn_rsp_data", rsp_data, v.exp_data);
        chk("txn_rsp_err", 32'(rsp_err), 32'd0);
        chk("txn_addr_held", 32'(Addr_in), 32'(v.addr));
        tick();
        chk("txn_rsp_pulse_end", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b0, 16'h1234, 32'hDEAD_BEEF, 3, 32'h0,         1'b0, 32'h0};
        vecs[1] = '{1'b1, 16'hF00F, 32'h0,         1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[2] = '{1'b1, 16'h0001, 32'h0,         5, 32'h1234_5678, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b0, 16'hFFFF, 32'hA5A5_A5A5, 1, 32'h0,         1'b0, 32'h0};
        vecs[4] = '{1'b1, 16'h8000, 32'h0,         2, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};

        rst_n = 1'b0; req_valid = 1'b0; req_rdnwr = 1'b0; req_addr = '0; req_wdata = '0;
        command = 3'b000; Data_out = '0; data_out_vld = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 20; i++) begin
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_cmd_n", 32'(cmd_n), 32'd1);
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_count", 32'(fifo_count), 32'd0);
            tick();
        end

        // Fill to DEPTH while the controller is busy, reject a 9th push, then drain
        command = 3'b101;
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", 32'(req_ready), 32'd1);
            push_req(1'b0, 16'h0100 + 16'(i), 32'(i));
        end
        chk("fill_count8", 32'(fifo_count), 32'd8);
        chk("fill_ready_low", 32'(req_ready), 32'd0);
        push_req(1'b0, 16'h0999, 32'h9);
        chk("fill_reject", 32'(fifo_count), 32'd8);
        command = 3'b000;
        for (int i = 0; i < 8; i++) begin
            wait_cmd(10);
            chk("drain_addr", 32'(Addr_in), 32'h0100 + 32'(i));
            chk("drain_data", Data_in, 32'(i));
            chk("drain_count", 32'(fifo_count), 32'(7 - i));
            tick();
            command = 3'b011;
            tick();
            command = 3'b000;
            chk("drain_rsp", 32'(rsp_valid), 32'd1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("drain_no_extra", 32'(cmd_n), 32'd1);
            tick();
        end
        chk("drain_count0", 32'(fifo_count), 32'd0);

        // Timeout on a read, then the queued write issues
        push_req(1'b1, 16'h0AAA, 32'h0);
        push_req(1'b0, 16'h0BBB, 32'h5555_AAAA);
        wait_cmd(10);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                k = i;
                break;
            end
            chk("tmo_din_vld", 32'(Data_in_vld), 32'd0);
        end
        chk("tmo_latency", 32'(k), 32'd65);
        chk("tmo_err", 32'(rsp_err), 32'd1);
        chk("tmo_rdnwr", 32'(rsp_rdnwr), 32'd1);
        tick();
        chk("tmo_pulse_end", 32'(rsp_valid), 32'd0);
        tick();
        chk("tmo_next_issue", 32'(cmd_n), 32'd0);
        chk("tmo_next_addr", 32'(Addr_in), 32'h0BBB);
        tick();
        command = 3'b011;
        tick();
        command = 3'b000;
        chk("tmo_next_rsp", 32'(rsp_valid), 32'd1);
        chk("tmo_err_cleared", 32'(rsp_err), 32'd0);
        tick();

        // Single transactions from the table
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i]);
        end

        // Reset while a write is in WAIT with 3 more queued
        command = 3'b101;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, 16'h0200 + 16'(i), 32'h1111_1111 * 32'(i + 1));
        end
        command = 3'b000;
        tick();
        chk("rst_pre_issue", 32'(cmd_n), 32'd0);
        tick();
        chk("rst_pre_din_vld", 32'(Data_in_vld), 32'd1);
        chk("rst_pre_count", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_n", 32'(cmd_n), 32'd1);
        chk("rst_din_vld", 32'(Data_in_vld), 32'd0);
        chk("rst_rdnwr", 32'(RDnWR), 32'd0);
        chk("rst_addr", 32'(Addr_in), 32'd0);
        chk("rst_data_in", Data_in, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdnwr", 32'(rsp_rdnwr), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_cmd_n", 32'(cmd_n), 32'd1);
            chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_count", 32'(fifo_count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
